// File: rtl/oc_pkg.sv
// Shared types and constants for the operand collector and the RF controller.
package oc_pkg;

   localparam int NUM_OC = 4;
   localparam int OC_IDW = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;
   localparam int DATA_W = 32;
   localparam int REG_AW = 3;
   localparam int WARP_W = 3;
   localparam int OP_W   = 4;

   typedef enum logic [1:0] {
      OC_FREE  = 2'd0,
      OC_WAIT  = 2'd1,
      OC_READY = 2'd2
   } oc_state_e;

   typedef struct packed {
      logic [WARP_W-1:0] warp;
      logic [OP_W-1:0]   opcode;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] src_a;
      logic [DATA_W-1:0] src_b;
      logic              va;
      logic              vb;
   } oc_entry_t;

endpackage

// File: rtl/oc_rr_arbiter.sv
// Rotating-priority picker: first asserted request at or after ptr wins.
module oc_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_vld,
   output logic [IW-1:0] gnt_idx
);

   int idx;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: allocates issued instructions, requests RF rows, gathers read data
// and dispatches round-robin. Define OC_FWD_EN for same-cycle forwarding of the final operand.
module operand_collector
   import oc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [WARP_W-1:0] iss_warp,
   input  logic [OP_W-1:0]   iss_opcode,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] iss_rs_a,
   input  logic [REG_AW-1:0] iss_rs_b,
   input  logic              iss_need_b,
   output logic              req_en,
   output logic              req_2op,
   output logic [REG_AW-1:0] req_rowid_a,
   output logic [REG_AW-1:0] req_rowid_b,
   output logic [OC_IDW-1:0] req_ocid,
   input  logic              req_full,
   input  logic              rf_rd_valid,
   input  logic [OC_IDW-1:0] rf_rd_ocid,
   input  logic              rf_rd_slot,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [OC_IDW-1:0] ex_ocid,
   output logic [WARP_W-1:0] ex_warp,
   output logic [OP_W-1:0]   ex_opcode,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_src_a,
   output logic [DATA_W-1:0] ex_src_b,
   output logic              err_stray
);

   oc_state_e         st_q  [NUM_OC];
   oc_state_e         st_d  [NUM_OC];
   oc_entry_t         ent_q [NUM_OC];
   oc_entry_t         ent_d [NUM_OC];
   logic [OC_IDW-1:0] ptr_q, ptr_d, ptr_eff;

   logic              req_en_q, req_en_d, req_2op_q, req_2op_d;
   logic [REG_AW-1:0] req_ra_q, req_ra_d, req_rb_q, req_rb_d;
   logic [OC_IDW-1:0] req_ocid_q, req_ocid_d;

   logic              ex_valid_q, ex_valid_d;
   logic [OC_IDW-1:0] ex_ocid_q, ex_ocid_d;
   logic [WARP_W-1:0] ex_warp_q, ex_warp_d;
   logic [OP_W-1:0]   ex_op_q, ex_op_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
   logic              err_q, err_d;

   logic              any_free, alloc, hs;
   logic [OC_IDW-1:0] alloc_idx;
   logic [NUM_OC-1:0] rdy_mask;
   logic              gnt_vld;
   logic [OC_IDW-1:0] gnt_idx;
   logic              rd_stray, rd_done, fwd_hit;
   oc_entry_t         rd_ent;

   // Downward scan leaves the lowest-index FREE entry in alloc_idx.
   always_comb begin
      any_free  = 1'b0;
      alloc_idx = '0;
      rdy_mask  = '0;
      for (int i = NUM_OC - 1; i >= 0; i--) begin
         if (st_q[i] == OC_FREE) begin
            any_free  = 1'b1;
            alloc_idx = OC_IDW'(i);
         end
         rdy_mask[i] = (st_q[i] == OC_READY) && !(ex_valid_q && (ex_ocid_q == OC_IDW'(i)));
      end
   end

   assign iss_ready = any_free && !req_full;
   assign alloc     = iss_valid && iss_ready;
   assign hs        = ex_valid_q && ex_ready;
   assign ptr_eff   = hs ? (ex_ocid_q + OC_IDW'(1)) : ptr_q;

   oc_rr_arbiter #(.N(NUM_OC), .IW(OC_IDW)) u_arb (
      .req     (rdy_mask),
      .ptr     (ptr_eff),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      rd_ent   = ent_q[rf_rd_ocid];
      rd_stray = (st_q[rf_rd_ocid] == OC_FREE) ||
                 (rf_rd_slot ? ent_q[rf_rd_ocid].vb : ent_q[rf_rd_ocid].va);
      if (rf_rd_slot) begin
         rd_ent.src_b = rf_rd_data;
         rd_ent.vb    = 1'b1;
      end else begin
         rd_ent.src_a = rf_rd_data;
         rd_ent.va    = 1'b1;
      end
      rd_done = rf_rd_valid && !rd_stray && rd_ent.va && rd_ent.vb;
   end

`ifdef OC_FWD_EN
   logic any_ready;

   always_comb begin
      any_ready = 1'b0;
      for (int i = 0; i < NUM_OC; i++) begin
         if (st_q[i] == OC_READY) any_ready = 1'b1;
      end
   end

   assign fwd_hit = rd_done && !any_ready && !ex_valid_q;

   always_comb begin
      ex_valid  = ex_valid_q;
      ex_ocid   = ex_ocid_q;
      ex_warp   = ex_warp_q;
      ex_opcode = ex_op_q;
      ex_rd     = ex_rd_q;
      ex_src_a  = ex_a_q;
      ex_src_b  = ex_b_q;
      if (fwd_hit) begin
         ex_valid  = 1'b1;
         ex_ocid   = rf_rd_ocid;
         ex_warp   = rd_ent.warp;
         ex_opcode = rd_ent.opcode;
         ex_rd     = rd_ent.rd;
         ex_src_a  = rd_ent.src_a;
         ex_src_b  = rd_ent.src_b;
      end
   end
`else
   assign fwd_hit   = 1'b0;
   assign ex_valid  = ex_valid_q;
   assign ex_ocid   = ex_ocid_q;
   assign ex_warp   = ex_warp_q;
   assign ex_opcode = ex_op_q;
   assign ex_rd     = ex_rd_q;
   assign ex_src_a  = ex_a_q;
   assign ex_src_b  = ex_b_q;
`endif

   always_comb begin
      st_d       = st_q;
      ent_d      = ent_q;
      ptr_d      = ptr_q;
      req_en_d   = 1'b0;
      req_2op_d  = req_2op_q;
      req_ra_d   = req_ra_q;
      req_rb_d   = req_rb_q;
      req_ocid_d = req_ocid_q;
      ex_valid_d = ex_valid_q;
      ex_ocid_d  = ex_ocid_q;
      ex_warp_d  = ex_warp_q;
      ex_op_d    = ex_op_q;
      ex_rd_d    = ex_rd_q;
      ex_a_d     = ex_a_q;
      ex_b_d     = ex_b_q;
      err_d      = err_q;

      if (hs) begin
         st_d[ex_ocid_q] = OC_FREE;
         ptr_d           = ptr_eff;
      end

      if (rf_rd_valid) begin
         if (rd_stray) begin
            err_d = 1'b1;
         end else begin
            ent_d[rf_rd_ocid] = rd_ent;
            if (rd_done) st_d[rf_rd_ocid] = OC_READY;
         end
      end

      if (alloc) begin
         ent_d[alloc_idx].warp   = iss_warp;
         ent_d[alloc_idx].opcode = iss_opcode;
         ent_d[alloc_idx].rd     = iss_rd;
         ent_d[alloc_idx].src_a  = '0;
         ent_d[alloc_idx].src_b  = '0;
         ent_d[alloc_idx].va     = 1'b0;
         ent_d[alloc_idx].vb     = !iss_need_b;
         st_d[alloc_idx]         = OC_WAIT;
         req_en_d                = 1'b1;
         req_ocid_d              = alloc_idx;
         req_ra_d                = iss_rs_a;
         req_rb_d                = iss_rs_b;
         req_2op_d               = iss_need_b;
      end

      // The output register only advances when empty or being consumed.
      if (!ex_valid_q || ex_ready) begin
         ex_valid_d = gnt_vld;
         if (gnt_vld) begin
            ex_ocid_d = gnt_idx;
            ex_warp_d = ent_q[gnt_idx].warp;
            ex_op_d   = ent_q[gnt_idx].opcode;
            ex_rd_d   = ent_q[gnt_idx].rd;
            ex_a_d    = ent_q[gnt_idx].src_a;
            ex_b_d    = ent_q[gnt_idx].src_b;
         end
      end

      if (fwd_hit) begin
         if (ex_ready) begin
            st_d[rf_rd_ocid] = OC_FREE;
            ptr_d            = rf_rd_ocid + OC_IDW'(1);
         end else begin
            ex_valid_d = 1'b1;
            ex_ocid_d  = rf_rd_ocid;
            ex_warp_d  = rd_ent.warp;
            ex_op_d    = rd_ent.opcode;
            ex_rd_d    = rd_ent.rd;
            ex_a_d     = rd_ent.src_a;
            ex_b_d     = rd_ent.src_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_OC; i++) begin
            st_q[i]  <= OC_FREE;
            ent_q[i] <= '0;
         end
         ptr_q      <= '0;
         req_en_q   <= 1'b0;
         req_2op_q  <= 1'b0;
         req_ra_q   <= '0;
         req_rb_q   <= '0;
         req_ocid_q <= '0;
         ex_valid_q <= 1'b0;
         ex_ocid_q  <= '0;
         ex_warp_q  <= '0;
         ex_op_q    <= '0;
         ex_rd_q    <= '0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         st_q       <= st_d;
         ent_q      <= ent_d;
         ptr_q      <= ptr_d;
         req_en_q   <= req_en_d;
         req_2op_q  <= req_2op_d;
         req_ra_q   <= req_ra_d;
         req_rb_q   <= req_rb_d;
         req_ocid_q <= req_ocid_d;
         ex_valid_q <= ex_valid_d;
         ex_ocid_q  <= ex_ocid_d;
         ex_warp_q  <= ex_warp_d;
         ex_op_q    <= ex_op_d;
         ex_rd_q    <= ex_rd_d;
         ex_a_q     <= ex_a_d;
         ex_b_q     <= ex_b_d;
         err_q      <= err_d;
      end
   end

   assign req_en      = req_en_q;
   assign req_2op     = req_2op_q;
   assign req_rowid_a = req_ra_q;
   assign req_rowid_b = req_rb_q;
   assign req_ocid    = req_ocid_q;
   assign err_stray   = err_q;

endmodule
